// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, instruction field positions and sequencer states
package cpu_pkg;

  localparam int OP_HI  = 11;
  localparam int OP_LO  = 9;
  localparam int RD_HI  = 8;
  localparam int RD_LO  = 7;
  localparam int RS_HI  = 6;
  localparam int RS_LO  = 5;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_4x4.sv
// rtl/regfile_4x4.sv - 4x4-bit register file, two async read ports, debug read, one sync write
module regfile_4x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [3:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [3:0] rdata_b,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);

  logic [3:0] regs [4];

  // single write port; asynchronous clear of all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle fetch/decode/exec/writeback sequencer for the 4-bit CPU
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W     = 4,
  parameter int ALU_WAIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [11:0]     imem_rdata,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  output logic            alu_sel,
  input  logic [3:0]      alu_res,
  input  logic            alu_eq,
  output logic            busy,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [3:0]      dbg_data
);

  // a zero settle window would skip EXEC entirely, so clamp to one cycle
  localparam int WAIT_N = (ALU_WAIT < 1) ? 1 : ALU_WAIT;
  localparam int CNT_W  = $clog2(WAIT_N + 1);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt, pc_inc;
  logic [11:0]       instr;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        res_q;
  logic              eq_q;
  logic              ld_instr, ld_cnt, sample;
  logic              rf_we;
  logic [3:0]        rf_wdata;
  logic [3:0]        rd_a, rd_b;
  logic [2:0]        op;
  logic [1:0]        rd;
  logic [3:0]        imm;

  assign op     = instr[OP_HI:OP_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign imm    = instr[IMM_HI:IMM_LO];
  assign pc_inc = pc + PC_W'(1);

  // operands are read straight from the incoming word so they are valid in DECODE
  regfile_4x4 u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (rf_wdata),
    .raddr_a  (imem_rdata[RD_HI:RD_LO]),
    .rdata_a  (rd_a),
    .raddr_b  (imem_rdata[RS_HI:RS_LO]),
    .rdata_b  (rd_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state, pc update, register write strobe and fetch request
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    imem_req  = 1'b0;
    ld_instr  = 1'b0;
    ld_cnt    = 1'b0;
    sample    = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = res_q;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ld_instr  = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        case (op)
          OP_ADD, OP_NAND, OP_BEQ: begin
            ld_cnt    = 1'b1;
            state_nxt = EXEC;
          end
          OP_LDI: begin
            rf_we     = 1'b1;
            rf_wdata  = imm;
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
          OP_JMP: begin
            pc_nxt    = PC_W'(imm);
            state_nxt = FETCH;
          end
          OP_HALT: state_nxt = HALT;
          default: begin
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
        endcase
      end
      EXEC: begin
        if (cnt == CNT_W'(1)) begin
          sample    = 1'b1;
          state_nxt = WB;
        end
      end
      WB: begin
        state_nxt = FETCH;
        if (op == OP_BEQ) begin
          pc_nxt = eq_q ? PC_W'(imm) : pc_inc;
        end else begin
          rf_we  = 1'b1;
          pc_nxt = pc_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: pc, instruction latch, settle counter, ALU operand/result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      instr   <= 12'd0;
      cnt     <= '0;
      res_q   <= 4'd0;
      eq_q    <= 1'b0;
      alu_a   <= 4'd0;
      alu_b   <= 4'd0;
      alu_sel <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (ld_instr) begin
        instr   <= imem_rdata;
        alu_a   <= rd_a;
        alu_b   <= rd_b;
        alu_sel <= (imem_rdata[OP_HI:OP_LO] == OP_NAND);
      end
      if (ld_cnt)              cnt <= CNT_W'(WAIT_N);
      else if (state == EXEC)  cnt <= cnt - CNT_W'(1);
      if (sample) begin
        res_q <= alu_res;
        eq_q  <= alu_eq;
      end
    end
  end

  assign imem_addr = pc;
  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - directed self-checking bench for cpu_ctrl
module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [1:0]  dbg_sel = 2'd0;

  logic        imem_req, imem_ack, alu_sel, alu_eq, busy, halted;
  logic [3:0]  imem_addr, alu_a, alu_b, alu_res, dbg_data;
  logic [11:0] imem_rdata;

  logic        imem_req1, imem_ack1, alu_sel1, alu_eq1, busy1, halted1;
  logic [3:0]  imem_addr1, alu_a1, alu_b1, alu_res1, dbg_data1;
  logic [11:0] imem_rdata1;

  logic [11:0] imem [16];
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  int          ack_cnt = 0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  logic [3:0]  tr_a [4096];
  logic [3:0]  tr_b [4096];
  logic [3:0]  tr_addr [4096];
  logic        tr_sel [4096];
  logic        tr_req [4096];
  int          ack_cyc [64];
  logic [3:0]  ack_addr [64];
  int          n_ack = 0;
  int          ack1_cyc [64];
  int          n_ack1 = 0;

  always #5 clk = ~clk;

  cpu_ctrl #(.PC_W(4), .ALU_WAIT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res), .alu_eq(alu_eq),
    .busy(busy), .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  cpu_ctrl #(.PC_W(4), .ALU_WAIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_ack1), .imem_rdata(imem_rdata1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_res(alu_res1), .alu_eq(alu_eq1),
    .busy(busy1), .halted(halted1), .dbg_sel(dbg_sel), .dbg_data(dbg_data1)
  );

  // instruction memory and ALU models
  assign imem_rdata  = imem[imem_addr];
  assign imem_rdata1 = imem[imem_addr1];
  assign imem_ack    = (imem_req && (ack_cnt >= ack_delay)) || ack_force;
  assign imem_ack1   = imem_req1;
  assign alu_res     = alu_sel ? ~(alu_a & alu_b) : (alu_a + alu_b);
  assign alu_eq      = (alu_a == alu_b);
  assign alu_res1    = alu_sel1 ? ~(alu_a1 & alu_b1) : (alu_a1 + alu_b1);
  assign alu_eq1     = (alu_a1 == alu_b1);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ack_cnt <= (imem_req && !imem_ack) ? ack_cnt + 1 : 0;
  end

  // per-cycle trace and accepted-fetch log, sampled mid-cycle
  always @(negedge clk) begin
    if (cyc < 4096) begin
      tr_a[cyc] = alu_a; tr_b[cyc] = alu_b; tr_sel[cyc] = alu_sel;
      tr_req[cyc] = imem_req; tr_addr[cyc] = imem_addr;
    end
    if (imem_req && imem_ack && n_ack < 64) begin
      ack_cyc[n_ack] = cyc; ack_addr[n_ack] = imem_addr; n_ack = n_ack + 1;
    end
    if (imem_req1 && imem_ack1 && n_ack1 < 64) begin
      ack1_cyc[n_ack1] = cyc; n_ack1 = n_ack1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [3:0] imm);
    return {op, rd, rs, 1'b0, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = enc(OP_HALT, 2'd0, 2'd0, 4'd0);
  endtask

  task automatic load_add_prog();
    clear_mem();
    imem[0] = enc(OP_LDI, 2'd1, 2'd0, 4'd5);
    imem[1] = enc(OP_LDI, 2'd2, 2'd0, 4'd9);
    imem[2] = enc(OP_ADD, 2'd1, 2'd2, 4'd0);
    imem[3] = enc(OP_HALT, 2'd0, 2'd0, 4'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_ack = 0; n_ack1 = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k = 0;
    while (!halted && k < budget) begin @(posedge clk); #1; k++; end
    check({tag, "_halted"}, halted, 1);
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int k = 0;
    while (n_ack < n && k < budget) begin @(posedge clk); #1; k++; end
    check({tag, "_fetches"}, (n_ack >= n), 1);
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [3:0] v);
    dbg_sel = r; #1 v = dbg_data;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int c, ok, cnt_sel, cnt_req, cnt_14, k;

    // test 1: ADD program, same-cycle ack, stray ack outside FETCH
    load_add_prog();
    ack_force = 1'b1;
    do_reset();
    check("rst_outs", {imem_req, busy, halted, alu_sel, alu_a, alu_b, imem_addr}, 0);
    read_reg(2'd1, v);
    check("rst_dbg", v, 0);
    pulse_start();
    wait_halt("t1", 100);
    read_reg(2'd1, v); check("t1_r1", v, 4'hE);
    read_reg(2'd2, v); check("t1_r2", v, 4'h9);
    check("t1_busy", busy, 0);
    check("t1_nfetch", n_ack, 4);
    check("t1_ldi_lat", ack_cyc[1] - ack_cyc[0], 2);
    check("t1_add_lat", ack_cyc[3] - ack_cyc[2], 6);
    c = ack_cyc[2]; ok = 1;
    for (int j = 1; j <= 4; j++)
      if (tr_a[c+j] !== 4'd5 || tr_b[c+j] !== 4'd9 || tr_sel[c+j] !== 1'b0) ok = 0;
    check("t1_ops_stable", ok, 1);

    // restart from HALT: fetch at pc 0 with registers intact
    n_ack = 0;
    pulse_start();
    wait_acks("rs", 1, 20);
    check("rs_addr", ack_addr[0], 0);
    read_reg(2'd1, v); check("rs_r1", v, 4'hE);
    read_reg(2'd2, v); check("rs_r2", v, 4'h9);
    ack_force = 1'b0;

    // test 2: NAND
    clear_mem();
    imem[0] = enc(OP_LDI, 2'd0, 2'd0, 4'hF);
    imem[1] = enc(OP_LDI, 2'd3, 2'd0, 4'h3);
    imem[2] = enc(OP_NAND, 2'd0, 2'd3, 4'd0);
    do_reset();
    pulse_start();
    wait_halt("t2", 100);
    read_reg(2'd0, v); check("t2_r0", v, 4'hC);
    read_reg(2'd3, v); check("t2_r3", v, 4'h3);
    check("t2_nand_lat", ack_cyc[3] - ack_cyc[2], 6);
    cnt_sel = 0;
    for (int j = ack_cyc[0]; j <= ack_cyc[3] + 1; j++) if (tr_sel[j] === 1'b1) cnt_sel++;
    check("t2_sel_cycles", cnt_sel, 6);
    check("t2_sel_after", tr_sel[ack_cyc[3] + 1], 0);

    // test 3: BEQ taken then not taken
    clear_mem();
    imem[0] = enc(OP_LDI, 2'd1, 2'd0, 4'd7);
    imem[1] = enc(OP_LDI, 2'd2, 2'd0, 4'd7);
    imem[2] = enc(OP_NOP, 2'd0, 2'd0, 4'd0);
    imem[3] = enc(OP_BEQ, 2'd1, 2'd2, 4'd6);
    do_reset();
    pulse_start();
    wait_halt("t3a", 100);
    check("t3a_target", ack_addr[4], 6);
    check("t3a_nop_lat", ack_cyc[3] - ack_cyc[2], 2);
    check("t3a_beq_lat", ack_cyc[4] - ack_cyc[3], 6);
    imem[1] = enc(OP_LDI, 2'd2, 2'd0, 4'd8);
    do_reset();
    pulse_start();
    wait_halt("t3b", 100);
    check("t3b_target", ack_addr[4], 4);

    // test 4: JMP to 14, JMP 15, NOP wraps to 0, ack delayed 3 cycles
    clear_mem();
    imem[0]  = enc(OP_JMP, 2'd0, 2'd0, 4'd14);
    imem[14] = enc(OP_JMP, 2'd0, 2'd0, 4'd15);
    imem[15] = enc(OP_NOP, 2'd0, 2'd0, 4'd0);
    ack_delay = 3;
    do_reset();
    pulse_start();
    wait_acks("t4", 4, 200);
    check("t4_a1", ack_addr[1], 14);
    check("t4_a2", ack_addr[2], 15);
    check("t4_wrap", ack_addr[3], 0);
    check("t4_jmp_lat", ack_cyc[1] - ack_cyc[0], 5);
    cnt_req = 0; cnt_14 = 0;
    for (int j = ack_cyc[0] + 1; j <= ack_cyc[1]; j++) begin
      if (tr_req[j] === 1'b1) cnt_req++;
      if (tr_req[j] === 1'b1 && tr_addr[j] === 4'd14) cnt_14++;
    end
    check("t4_req_cycles", cnt_req, 4);
    check("t4_addr_stable", cnt_14, 4);
    // async reset while a fetch is outstanding
    k = 0;
    while (!imem_req && k < 20) begin @(posedge clk); #1; k++; end
    #2 rst_n = 1'b0;
    #1 check("t4_rst_req", {imem_req, busy}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ack_delay = 0;

    // tight loop: JMP to its own address
    clear_mem();
    imem[0] = enc(OP_JMP, 2'd0, 2'd0, 4'd0);
    do_reset();
    pulse_start();
    wait_acks("tl", 3, 50);
    check("tl_addr", {ack_addr[1], ack_addr[2]}, 0);
    check("tl_lat", ack_cyc[2] - ack_cyc[1], 2);

    // test 5: start while busy ignored, async reset during EXEC
    load_add_prog();
    do_reset();
    pulse_start();
    wait_acks("t5a", 2, 20);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_acks("t5b", 3, 20);
    check("t5_start_ignored", ack_addr[2], 2);
    @(posedge clk); #1;
    check("t5_in_exec", {busy, alu_a, alu_b}, {1'b1, 4'd5, 4'd9});
    dbg_sel = 2'd1;
    #2 rst_n = 1'b0;
    #1 check("t5_rst_outs", {imem_req, busy, halted, alu_sel, alu_a, alu_b, dbg_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    k = n_ack;
    repeat (3) @(posedge clk);
    #1 check("t5_idle", {busy, dbg_data}, 0);
    check("t5_no_fetch", n_ack, k);

    // ALU_WAIT=1 instance: ADD takes 4 cycles
    load_add_prog();
    do_reset();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    k = 0;
    while (!halted1 && k < 100) begin @(posedge clk); #1; k++; end
    check("w1_halted", halted1, 1);
    check("w1_add_lat", ack1_cyc[3] - ack1_cyc[2], 4);
    dbg_sel = 2'd1;
    #1 check("w1_r1", dbg_data1, 4'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Multi-cycle sequencer for the 4-bit CPU: fetches 12-bit instructions, owns a 4x4-bit register file and drives the shared gate-level ALU (add/nand, eq flag).
- Holds ALU operands stable for a programmable settle window before sampling the result, which covers the ALU's ~51 ns combinational delay.
- Sits between instruction memory and the ALU.

Parameters:
- PC_W, 4, program counter width (instruction space 2^PC_W words).
- ALU_WAIT, 3, EXEC cycles operands are held before result/eq are sampled; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: leave IDLE/HALT and begin execution at PC 0.
- imem_req  output  1  fetch request, held until ack.
- imem_addr  output  PC_W  fetch address (= pc).
- imem_ack  input  1  instruction valid this cycle.
- imem_rdata  input  12  instruction word.
- alu_a  output  4  ALU operand A.
- alu_b  output  4  ALU operand B.
- alu_sel  output  1  0 = add, 1 = nand.
- alu_res  input  4  ALU result.
- alu_eq  input  1  ALU equality flag.
- busy  output  1  high in any state other than IDLE/HALT.
- halted  output  1  high in HALT.
- dbg_sel  input  2  register debug select.
- dbg_data  output  4  combinational read of reg[dbg_sel].

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset value of every output: state=IDLE, pc=0, all regs=0, instr=0, wait counter=0; imem_req=0, alu_a=0, alu_b=0, alu_sel=0, busy=0, halted=0. dbg_data follows regs, so it reads 0 after reset.
- Instruction fields: op[11:9], rd[8:7], rs[6:5], bit4 ignored, imm[3:0].
- Opcodes:
  - 000 ADD: rd <= rd + rs, carry discarded, mod 16.
  - 001 NAND: rd <= ~(rd & rs).
  - 010 LDI: rd <= imm.
  - 011 BEQ: if rd == rs (per alu_eq) then pc <= imm, else pc+1.
  - 100 JMP: pc <= imm.
  - 101 HALT.
  - 110/111: NOP, pc+1.
- States and transitions:
  - IDLE: wait for start, then pc <= 0 and go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On the edge where imem_ack=1, latch imem_rdata and go to DECODE. Ack may be combinational in the same cycle as req (minimum 1 cycle in FETCH).
  - DECODE (1 cycle): drive alu_a=reg[rd], alu_b=reg[rs], alu_sel=1 for NAND else 0.
    - ADD, NAND, BEQ: load counter with ALU_WAIT and go to EXEC.
    - LDI, JMP, NOP: apply effect, go to FETCH.
    - HALT: go to HALT.
  - EXEC: operands and alu_sel held constant; counter decrements each cycle. On the cycle the counter reaches 1, sample alu_res/alu_eq and go to WB.
  - WB (1 cycle): ADD/NAND write rd, pc+1. BEQ updates pc. Then go to FETCH.
  - HALT: halted=1, pc frozen. start → pc <= 0, go to FETCH. Registers are preserved.
- Latency (ack in first FETCH cycle):
  - ADD/NAND/BEQ = 1 + 1 + ALU_WAIT + 1 cycles per instruction (6 at default ALU_WAIT=3).
  - LDI/JMP/NOP = 2 cycles.
- alu_a/alu_b/alu_sel keep their last driven values outside DECODE/EXEC. They change only on DECODE entry.
- Boundary conditions:
  - pc+1 wraps from 2^PC_W−1 to 0.
  - BEQ/JMP to the current address gives a legal tight loop.
  - start is ignored while busy.
  - rd==rs is legal (ADD r1,r1 doubles).
  - imem_ack outside FETCH is ignored.
  - Reset mid-operation: imem_req drops immediately (async) and no register write occurs.
  - ALU_WAIT=1: exactly one EXEC cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_ADD..OP_HALT);
  - field bit positions;
  - state encoding (IDLE, FETCH, DECODE, EXEC, WB, HALT).
- One sub-module, regfile_4x4: 4 entries x 4 bits, two asynchronous read ports plus a debug read port, one synchronous write port, async active-low clear.

Test Plan:
- Reset, then start; program LDI r1,5; LDI r2,9; ADD r1,r2; HALT with ack in the same cycle as req → r1=14 (0xE), halted=1, ADD takes 6 cycles, alu_a=5 and alu_b=9 stable for all 3 EXEC cycles.
- LDI r0,0xF; LDI r3,0x3; NAND r0,r3; HALT → r0=0xC, alu_sel=1 only during that instruction.
- LDI r1,7; LDI r2,7; BEQ r1,r2,imm=6 → next imem_addr=6. Change r2 to 8 → next imem_addr=4 (pc+1).
- JMP imm=15 at pc 14, NOP at 15 → next fetch address 0 (wrap). Ack delayed 3 cycles → imem_req held high 4 cycles with imem_addr stable.
- Assert rst_n=0 during EXEC of ADD r1,r2 → outputs return to reset values with no clock edge, r1 unchanged (0), state IDLE. A start pulse while busy has no effect.
- In HALT, pulse start → fetch restarts at pc 0 with registers intact. Run with ALU_WAIT=1 → ADD takes 4 cycles.
